// File: rtl/uart_pkg.sv
// Shared UART receive definitions: byte FSM state encoding and default framing constants.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam int DEF_DBITS   = 8;
  localparam int DEF_SB_TICK = 16;

  // Tick index at the centre of the start bit.
  localparam logic [3:0] MID_TICK = 4'd7;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte deserialiser on a 16x oversampling tick; emits single-cycle accept/stop-error strobes.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int DBITS   = DEF_DBITS,
  parameter int SB_TICK = DEF_SB_TICK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  input  logic             sample_tick,
  output logic [DBITS-1:0] data,
  output logic             byte_valid,
  output logic             stop_err,
  output logic             idle
);

  localparam int NB = (DBITS > 1) ? $clog2(DBITS) : 1;

  logic            rx_q1;
  logic            rx_q2;
  rx_state_e       state;
  logic [3:0]      tick_cnt;
  logic [NB-1:0]   bit_cnt;
  logic [DBITS-1:0] shreg;
  logic            stop_sample;

  // Two-flop synchroniser, reset to the idle-high line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_q1 <= 1'b1;
      rx_q2 <= 1'b1;
    end else begin
      rx_q1 <= rx;
      rx_q2 <= rx_q1;
    end
  end

  // Byte FSM: start-bit qualification, LSB-first data shift, stop-bit sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      tick_cnt <= 4'd0;
      bit_cnt  <= {NB{1'b0}};
      shreg    <= {DBITS{1'b0}};
    end else begin
      case (state)
        ST_IDLE: begin
          if (!rx_q2) begin
            state    <= ST_START;
            tick_cnt <= 4'd0;
          end
        end
        ST_START: begin
          if (sample_tick) begin
            if (tick_cnt == MID_TICK) begin
              if (!rx_q2) begin
                state    <= ST_DATA;
                tick_cnt <= 4'd0;
                bit_cnt  <= {NB{1'b0}};
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (sample_tick) begin
            if (tick_cnt == 4'd15) begin
              tick_cnt <= 4'd0;
              shreg    <= {rx_q2, shreg[DBITS-1:1]};
              if (bit_cnt == NB'(DBITS - 1)) begin
                state <= ST_STOP;
              end else begin
                bit_cnt <= bit_cnt + {{(NB-1){1'b0}}, 1'b1};
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        ST_STOP: begin
          if (sample_tick) begin
            if (tick_cnt == 4'(SB_TICK - 1)) begin
              state <= ST_IDLE;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Strobes are combinational so the frame layer can register them on the same tick.
  assign stop_sample = (state == ST_STOP) && sample_tick && (tick_cnt == 4'(SB_TICK - 1));
  assign byte_valid  = stop_sample && rx_q2;
  assign stop_err    = stop_sample && !rx_q2;
  assign idle        = (state == ST_IDLE);
  assign data        = shreg;

endmodule

// File: rtl/uart_rx_frame.sv
// Multi-byte UART receiver: gathers FRAME_BYTES accepted bytes into one word, first byte in the MSBs.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DBITS         = DEF_DBITS,
  parameter int SB_TICK       = DEF_SB_TICK,
  parameter int FRAME_BYTES   = 4,
  parameter int TIMEOUT_TICKS = 320,
  parameter int TO_BITS       = 9
) (
  input  logic                         clk_100MHz,
  input  logic                         reset,
  input  logic                         rx,
  input  logic                         sample_tick,
  output logic [DBITS*FRAME_BYTES-1:0] frame_out,
  output logic                         frame_valid,
  output logic                         frame_err,
  output logic                         frame_timeout,
  output logic                         busy
);

  localparam int FW   = DBITS * FRAME_BYTES;
  localparam int BC_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

  logic [DBITS-1:0]   byte_data;
  logic               byte_valid;
  logic               stop_err;
  logic               idle;
  logic [BC_W-1:0]    byte_cnt;
  logic [FW-1:0]      shreg;
  logic [FW-1:0]      next_word;
  logic [TO_BITS-1:0] to_cnt;
  logic               partial;
  logic               to_fire;

  uart_rx_byte #(
    .DBITS   (DBITS),
    .SB_TICK (SB_TICK)
  ) u_byte (
    .clk         (clk_100MHz),
    .reset       (reset),
    .rx          (rx),
    .sample_tick (sample_tick),
    .data        (byte_data),
    .byte_valid  (byte_valid),
    .stop_err    (stop_err),
    .idle        (idle)
  );

  assign next_word = {shreg[FW-DBITS-1:0], byte_data};
  assign partial   = (byte_cnt != {BC_W{1'b0}});
  assign to_fire   = idle && partial && sample_tick && (to_cnt == TO_BITS'(TIMEOUT_TICKS - 1));
  assign busy      = !idle || partial;

  // Inter-byte idle timer; only runs while a partial frame waits in IDLE.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      to_cnt <= {TO_BITS{1'b0}};
    end else if (!idle || !partial || to_fire) begin
      to_cnt <= {TO_BITS{1'b0}};
    end else if (sample_tick) begin
      to_cnt <= to_cnt + {{(TO_BITS-1){1'b0}}, 1'b1};
    end else begin
      to_cnt <= to_cnt;
    end
  end

  // Frame assembly and registered status pulses; a stop error discards the partial frame.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      byte_cnt      <= {BC_W{1'b0}};
      shreg         <= {FW{1'b0}};
      frame_out     <= {FW{1'b0}};
      frame_valid   <= 1'b0;
      frame_err     <= 1'b0;
      frame_timeout <= 1'b0;
    end else begin
      frame_valid   <= 1'b0;
      frame_err     <= 1'b0;
      frame_timeout <= 1'b0;
      if (stop_err) begin
        byte_cnt  <= {BC_W{1'b0}};
        frame_err <= 1'b1;
      end else if (byte_valid) begin
        shreg <= next_word;
        if (byte_cnt == BC_W'(FRAME_BYTES - 1)) begin
          frame_out   <= next_word;
          frame_valid <= 1'b1;
          byte_cnt    <= {BC_W{1'b0}};
        end else begin
          byte_cnt <= byte_cnt + {{(BC_W-1){1'b0}}, 1'b1};
        end
      end else if (to_fire) begin
        byte_cnt      <= {BC_W{1'b0}};
        frame_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: stimulus queues expected events, a monitor checks each output pulse.
module tb_uart_rx_frame;

  localparam int BIT_CLKS = 64;  // 16 ticks at one tick per 4 clocks

  logic        clk_100MHz = 1'b0;
  logic        reset      = 1'b1;
  logic        rx         = 1'b1;
  logic        sample_tick = 1'b0;
  logic [31:0] frame_out;
  logic        frame_valid;
  logic        frame_err;
  logic        frame_timeout;
  logic        busy;

  typedef struct {
    logic [2:0]  kind;   // {valid, err, timeout}
    logic [31:0] data;
  } ev_t;

  ev_t q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  uart_rx_frame dut (
    .clk_100MHz    (clk_100MHz),
    .reset         (reset),
    .rx            (rx),
    .sample_tick   (sample_tick),
    .frame_out     (frame_out),
    .frame_valid   (frame_valid),
    .frame_err     (frame_err),
    .frame_timeout (frame_timeout),
    .busy          (busy)
  );

  initial forever #5 clk_100MHz = ~clk_100MHz;

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk_100MHz);
      sample_tick = (ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [2:0] kind, input logic [31:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    q.push_back(e);
  endtask

  // Monitor: every output pulse must match the next queued expectation.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk_100MHz);
      if (frame_valid || frame_err || frame_timeout) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event: got v/e/t=%b, expected none", {frame_valid, frame_err, frame_timeout});
        end else begin
          e = q.pop_front();
          check("event_kind", {29'd0, frame_valid, frame_err, frame_timeout}, {29'd0, e.kind});
          if (e.kind == 3'b100) check("frame_out", frame_out, e.data);
        end
      end
    end
  end

  task automatic send_bit(input logic b, input int clks);
    rx = b;
    repeat (clks) @(negedge clk_100MHz);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit stop_ok);
    send_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) send_bit(d[i], BIT_CLKS);
    if (stop_ok) begin
      send_bit(1'b1, BIT_CLKS);
    end else begin
      send_bit(1'b0, 40);
      rx = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 3000 && q.size() != 0; i++) @(negedge clk_100MHz);
    check(name, q.size(), 32'd0);
    q.delete();
  endtask

  initial begin
    repeat (5) @(negedge clk_100MHz);
    check("reset_frame_out", frame_out, 32'h0);
    check("reset_pulses", {29'd0, frame_valid, frame_err, frame_timeout}, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'h0);
    reset = 1'b0;
    send_bit(1'b1, BIT_CLKS);

    // 1: basic frame
    expect_ev(3'b100, 32'h12345678);
    send_frame(32'h12345678);
    drain("t1_drain");
    check("t1_busy_after", {31'd0, busy}, 32'h0);

    // 2: start-bit glitch
    send_bit(1'b0, 16);
    send_bit(1'b1, BIT_CLKS);
    check("t2_busy", {31'd0, busy}, 32'h0);

    // 3: stop error drops the partial frame
    send_byte(8'h11, 1'b1);
    check("t3_busy_partial", {31'd0, busy}, 32'h1);
    expect_ev(3'b010, 32'h0);
    send_byte(8'h22, 1'b0);
    send_bit(1'b1, BIT_CLKS);
    drain("t3_err_drain");
    check("t3_busy_after_err", {31'd0, busy}, 32'h0);
    expect_ev(3'b100, 32'hA1A2A3A4);
    send_frame(32'hA1A2A3A4);
    drain("t3_drain");

    // 4: inter-byte timeout
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    expect_ev(3'b001, 32'h0);
    send_bit(1'b1, 320 * 4 + 100);
    drain("t4_to_drain");
    check("t4_frame_hold", frame_out, 32'hA1A2A3A4);
    check("t4_busy", {31'd0, busy}, 32'h0);
    expect_ev(3'b100, 32'hDEADBEEF);
    send_frame(32'hDEADBEEF);
    drain("t4_drain");

    // 5: reset mid-byte, then a frame with a long but legal gap
    send_byte(8'h99, 1'b1);
    send_byte(8'h88, 1'b1);
    send_bit(1'b0, BIT_CLKS);
    send_bit(1'b1, BIT_CLKS);
    send_bit(1'b0, 32);
    check("t5_busy_pre_reset", {31'd0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    check("t5_rst_frame_out", frame_out, 32'h0);
    check("t5_rst_busy", {31'd0, busy}, 32'h0);
    check("t5_rst_pulses", {29'd0, frame_valid, frame_err, frame_timeout}, 32'h0);
    repeat (3) @(negedge clk_100MHz);
    reset = 1'b0;
    send_bit(1'b1, 2 * BIT_CLKS);
    expect_ev(3'b100, 32'hCAFEF00D);
    send_byte(8'hCA, 1'b1);
    send_byte(8'hFE, 1'b1);
    send_bit(1'b1, 250 * 4);
    send_byte(8'hF0, 1'b1);
    send_byte(8'h0D, 1'b1);
    drain("t5_drain");

    // 6: eight bytes back to back
    expect_ev(3'b100, 32'h0123ABCD);
    expect_ev(3'b100, 32'h55AA0FF0);
    send_frame(32'h0123ABCD);
    send_frame(32'h55AA0FF0);
    drain("t6_drain");
    check("t6_frame_out", frame_out, 32'h55AA0FF0);
    check("t6_busy", {31'd0, busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
